// File: rtl/rv32i_mem_arbiter.sv
// Arbitrates a single-port unified memory between the fetch and load/store ports.
// Round-robin on contention, one transaction in flight, timeout-backed response.
module rv32i_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_err,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_err,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t     state, state_next;
  logic       owner;       // 1 = data port, 0 = fetch port
  logic       last_owner;
  logic [7:0] cnt;
  logic       win_if, win_d, resp_ok, resp_to, resp_any;

  always_comb begin
    state_next = state;
    win_if     = 1'b0;
    win_d      = 1'b0;
    resp_ok    = 1'b0;
    resp_to    = 1'b0;
    case (state)
      IDLE: begin
        // Fetch wins when alone, or when contested and data went last.
        if (if_req && (!d_req || last_owner)) begin
          win_if     = 1'b1;
          state_next = ISSUE;
        end else if (d_req) begin
          win_d      = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_gnt) state_next = RESP;
      end
      RESP: begin
        if (mem_rvalid) begin
          resp_ok    = 1'b1;
          state_next = IDLE;
        end else if (cnt == TO_LAST) begin
          resp_to    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign resp_any = resp_ok | resp_to;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      owner      <= 1'b0;
      last_owner <= 1'b1;
      cnt        <= '0;
      if_gnt     <= 1'b0;
      if_rvalid  <= 1'b0;
      if_rdata   <= '0;
      if_err     <= 1'b0;
      d_gnt      <= 1'b0;
      d_rvalid   <= 1'b0;
      d_rdata    <= '0;
      d_err      <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
    end else begin
      if_gnt    <= win_if;
      d_gnt     <= win_d;
      if_rvalid <= resp_any & ~owner;
      if_err    <= resp_to & ~owner;
      d_rvalid  <= resp_any & owner;
      d_err     <= resp_to & owner;

      if (win_if) begin
        mem_req    <= 1'b1;
        mem_we     <= 1'b0;
        mem_addr   <= if_addr;
        mem_wdata  <= '0;
        mem_wstrb  <= '0;
        owner      <= 1'b0;
        last_owner <= 1'b0;
      end else if (win_d) begin
        mem_req    <= 1'b1;
        mem_we     <= d_we;
        mem_addr   <= d_addr;
        mem_wdata  <= d_wdata;
        mem_wstrb  <= d_wstrb;
        owner      <= 1'b1;
        last_owner <= 1'b1;
      end

      if (state == ISSUE && mem_gnt) begin
        mem_req <= 1'b0;
        cnt     <= '0;
      end else if (state == RESP && !resp_any) begin
        cnt <= cnt + 8'd1;
      end

      // A timed-out response returns zero data; otherwise rdata holds.
      if (resp_any && !owner) if_rdata <= resp_ok ? mem_rdata : '0;
      if (resp_any && owner)  d_rdata  <= resp_ok ? mem_rdata : '0;
    end
  end

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Bench for rv32i_mem_arbiter: directed scenarios drive the memory side cycle by
// cycle; expected responses are queued and matched as rvalid pulses appear.
module tb_rv32i_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt, if_rvalid, if_err;
  logic [DW-1:0] if_rdata;
  logic          d_req, d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [3:0]    d_wstrb;
  logic          d_gnt, d_rvalid, d_err;
  logic [DW-1:0] d_rdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_wstrb;
  logic          mem_gnt, mem_rvalid;
  logic [DW-1:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic          port;   // 1 = data
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  exp_t sb[$];

  rv32i_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic p, input logic [DW-1:0] d, input logic e);
    exp_t x;
    x.port = p;
    x.data = d;
    x.err  = e;
    return x;
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  // Response monitor: every rvalid pulse must match the oldest queued expectation.
  initial begin
    exp_t e;
    logic          gp, ge;
    logic [DW-1:0] gd;
    forever begin
      @(negedge clk);
      if (if_rvalid === 1'b1 || d_rvalid === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rvalid_unexpected: if_rvalid=%b d_rvalid=%b, none expected", if_rvalid, d_rvalid);
        end else begin
          e  = sb.pop_front();
          gp = d_rvalid;
          gd = d_rvalid ? d_rdata : if_rdata;
          ge = d_rvalid ? d_err : if_err;
          if ({if_rvalid, d_rvalid} !== (e.port ? 2'b01 : 2'b10) || gd !== e.data || ge !== e.err) begin
            errors++;
            $display("FAIL rvalid_resp: got port=%b rvalid=%b%b data=%h err=%b, want port=%b data=%h err=%b",
                     gp, if_rvalid, d_rvalid, gd, ge, e.port, e.data, e.err);
          end
        end
      end
      if ((if_rvalid === 1'b0 && if_err !== 1'b0) || (d_rvalid === 1'b0 && d_err !== 1'b0)) begin
        checks++;
        errors++;
        $display("FAIL err_without_rvalid: if_err=%b d_err=%b, want 0", if_err, d_err);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  task automatic test_reset();
    logic [DW-1:0] v;
    rst = 1'b0; if_req = 1'b1; d_req = 1'b1;
    step(); step();
    checks++;
    if ({if_gnt, if_rvalid, if_rdata, if_err, d_gnt, d_rvalid, d_rdata, d_err,
         mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: if_gnt=%b d_gnt=%b mem_req=%b mem_addr=%h, want all 0",
               if_gnt, d_gnt, mem_req, mem_addr);
    end
    rst = 1'b1;
    step();
    checks++;
    if (if_gnt !== 1'b1 || d_gnt !== 1'b0 || mem_addr !== if_addr) begin
      errors++;
      $display("FAIL reset_first_grant: if_gnt=%b d_gnt=%b addr=%h, want 1 0 %h", if_gnt, d_gnt, mem_addr, if_addr);
    end
    if_req = 1'b0; d_req = 1'b0; mem_gnt = 1'b1;
    step();
    v = 32'h1111_1111;
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = v;
    sb.push_back(mk(1'b0, v, 1'b0));
    step();
    mem_rvalid = 1'b0;
    step();
  endtask

  task automatic test_single_fetch();
    if_req = 1'b1; if_addr = 32'h0000_0010;
    step();
    checks++;
    if (if_gnt !== 1'b1 || d_gnt !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h10 ||
        mem_we !== 1'b0 || mem_wstrb !== 4'h0 || mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL fetch_issue: gnt=%b/%b req=%b addr=%h we=%b strb=%h wdata=%h, want 1/0 1 00000010 0 0 0",
               if_gnt, d_gnt, mem_req, mem_addr, mem_we, mem_wstrb, mem_wdata);
    end
    if_req = 1'b0; mem_gnt = 1'b1;
    step();
    checks++;
    if (mem_req !== 1'b0 || if_gnt !== 1'b0) begin
      errors++;
      $display("FAIL fetch_req_width: mem_req=%b if_gnt=%b, want 0 0", mem_req, if_gnt);
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0050_0093;
    sb.push_back(mk(1'b0, 32'h0050_0093, 1'b0));
    step();
    checks++;
    if (if_rvalid !== 1'b1) begin
      errors++;
      $display("FAIL fetch_rvalid_timing: if_rvalid=%b, want 1", if_rvalid);
    end
    mem_rvalid = 1'b0; mem_rdata = 32'hFFFF_FFFF;
    step();
    checks++;
    if (if_rvalid !== 1'b0 || if_rdata !== 32'h0050_0093) begin
      errors++;
      $display("FAIL fetch_rdata_hold: rvalid=%b rdata=%h, want 0 00500093", if_rvalid, if_rdata);
    end
  endtask

  task automatic test_contention();
    logic exp_d;
    rst = 1'b0;
    step();
    rst = 1'b1;
    if_req = 1'b1; if_addr = 32'h0000_0200;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0100; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'hF;
    for (int k = 0; k < 4; k++) begin
      exp_d = k[0];
      step();
      checks++;
      if (if_gnt !== ~exp_d || d_gnt !== exp_d) begin
        errors++;
        $display("FAIL contention_grant_%0d: if_gnt=%b d_gnt=%b, want %b %b", k, if_gnt, d_gnt, ~exp_d, exp_d);
      end
      checks++;
      if (exp_d ? (mem_we !== 1'b1 || mem_addr !== 32'h100 || mem_wdata !== 32'hDEAD_BEEF || mem_wstrb !== 4'hF)
                : (mem_we !== 1'b0 || mem_addr !== 32'h200 || mem_wdata !== 32'h0 || mem_wstrb !== 4'h0)) begin
        errors++;
        $display("FAIL contention_mem_%0d: we=%b addr=%h wdata=%h strb=%h", k, mem_we, mem_addr, mem_wdata, mem_wstrb);
      end
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_1000 + 32'(k);
      sb.push_back(mk(exp_d, 32'h0000_1000 + 32'(k), 1'b0));
      step();
      mem_rvalid = 1'b0;
      if (k == 3) begin
        if_req = 1'b0; d_req = 1'b0;
      end
    end
    step();
  endtask

  task automatic test_backpressure();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0300;
    step();
    d_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h300 || d_gnt !== (i == 0) || if_gnt !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_cycle_%0d: req=%b addr=%h d_gnt=%b if_gnt=%b, want 1 00000300 %b 0",
                 i, mem_req, mem_addr, d_gnt, if_gnt, (i == 0));
      end
      mem_gnt = (i == 3);
      step();
    end
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_release: mem_req=%b, want 0", mem_req);
    end
    mem_gnt = 1'b0;
    step();
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_0001;
    sb.push_back(mk(1'b1, 32'hCAFE_0001, 1'b0));
    step();
    mem_rvalid = 1'b0;
    step();
  endtask

  task automatic run_timeout(input bit late_rvalid);
    logic          want_v;
    logic [DW-1:0] want_d;
    want_d = late_rvalid ? 32'h1234_5678 : 32'h0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0400;
    step();
    d_req = 1'b0; mem_gnt = 1'b1;
    sb.push_back(mk(1'b1, want_d, ~late_rvalid));
    for (int j = 1; j <= TO + 1; j++) begin
      step();
      mem_gnt = 1'b0;
      want_v = (j == TO + 1);
      checks++;
      if (d_rvalid !== want_v || (want_v && (d_err !== ~late_rvalid || d_rdata !== want_d))) begin
        errors++;
        $display("FAIL timeout_%0d_cycle_%0d: d_rvalid=%b d_err=%b d_rdata=%h, want %b %b %h",
                 late_rvalid, j, d_rvalid, d_err, d_rdata, want_v, ~late_rvalid, want_d);
      end
      mem_rvalid = late_rvalid && (j == TO);
      mem_rdata  = want_d;
    end
    mem_rvalid = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    run_timeout(1'b0);
    run_timeout(1'b1);
  endtask

  task automatic test_mid_reset();
    if_req = 1'b1; if_addr = 32'h0000_0500;
    step();
    if_req = 1'b0; mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    step();
    rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    step();
    rst = 1'b1; mem_rvalid = 1'b0;
    checks++;
    if ({if_gnt, if_rvalid, if_rdata, if_err, d_gnt, d_rvalid, d_rdata, d_err,
         mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: if_rvalid=%b if_rdata=%h mem_addr=%h d_rdata=%h, want all 0",
               if_rvalid, if_rdata, mem_addr, d_rdata);
    end
    for (int i = 0; i < 3; i++) begin
      mem_rvalid = (i == 0);
      step();
      checks++;
      if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0 || mem_req !== 1'b0) begin
        errors++;
        $display("FAIL midreset_quiet_%0d: if_rvalid=%b d_rvalid=%b mem_req=%b, want 0 0 0",
                 i, if_rvalid, d_rvalid, mem_req);
      end
    end
    mem_rvalid = 1'b0;
    if_req = 1'b1; if_addr = 32'h0000_0600;
    step();
    checks++;
    if (if_gnt !== 1'b1 || mem_req !== 1'b1 || mem_addr !== 32'h600) begin
      errors++;
      $display("FAIL midreset_next_grant: if_gnt=%b req=%b addr=%h, want 1 1 00000600", if_gnt, mem_req, mem_addr);
    end
    if_req = 1'b0; mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hA5A5_5A5A;
    sb.push_back(mk(1'b0, 32'hA5A5_5A5A, 1'b0));
    step();
    mem_rvalid = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b0; if_req = 1'b0; if_addr = 32'h0000_0080;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    test_reset();
    test_single_fetch();
    test_contention();
    test_backpressure();
    test_timeout();
    test_mid_reset();
    step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d responses outstanding, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32i_mem_arbiter.md
# rv32i_mem_arbiter

Shares one single-port unified memory between the `rv32i_core` instruction-fetch port and its load/store port. It accepts one transaction at a time, resolves simultaneous requests round-robin, and drives the memory-side request/grant handshake. It routes each response to the port that issued the request. A timeout counter guarantees the core always receives a response, even from an unresponsive memory. It sits between `rv32i_core` and the memory model, in the same hierarchy the `main_tb` bench instantiates.

## Interface
Parameters:
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width. `DATA_W/8` is the strobe width.
- `TIMEOUT`, default 15: maximum number of cycles spent waiting in RESP, legal range 1..255.

Ports:
- `clk`  in  1: clock. All logic is on the rising edge.
- `rst`  in  1: reset. Synchronous and active-low (0 = reset).
- `if_req`  in  1: fetch request. Held with `if_addr` until `if_gnt`.
- `if_addr`  in  ADDR_W: fetch address.
- `if_gnt`  out  1: one-cycle pulse; the fetch request has been accepted.
- `if_rvalid`  out  1: one-cycle pulse; `if_rdata`/`if_err` are valid.
- `if_rdata`  out  DATA_W: fetch data.
- `if_err`  out  1: the fetch timed out.
- `d_req`  in  1: data request. Held with the `d_*` inputs until `d_gnt`.
- `d_we`  in  1: 1 = store, 0 = load.
- `d_addr`  in  ADDR_W: data address.
- `d_wdata`  in  DATA_W: store data.
- `d_wstrb`  in  DATA_W/8: store byte enables.
- `d_gnt`  out  1: one-cycle pulse; the data request has been accepted.
- `d_rvalid`  out  1: one-cycle pulse; the load/store has completed.
- `d_rdata`  out  DATA_W: load data.
- `d_err`  out  1: the data access timed out.
- `mem_req`  out  1: memory request. Held until `mem_gnt`.
- `mem_we`  out  1: memory write enable.
- `mem_addr`  out  ADDR_W: memory address.
- `mem_wdata`  out  DATA_W: memory write data.
- `mem_wstrb`  out  DATA_W/8: memory byte enables.
- `mem_gnt`  in  1: memory has accepted the request.
- `mem_rvalid`  in  1: memory response. Asserted for both reads and writes.
- `mem_rdata`  in  DATA_W: memory read data.

## Operation
- FSM states: IDLE, ISSUE, RESP.
- **IDLE**
  - Samples `if_req` and `d_req`.
  - Only one request high: that port wins.
  - Both high: the winner is the port that is not `last_owner`.
  - On a win, at that edge:
    - latch the winner's address, `we`, `wdata`, `wstrb` into the `mem_*` registers;
    - set `owner` and `last_owner` to the winner;
    - set the winner's `*_gnt` = 1 for the next cycle only;
    - go to ISSUE.
  - A fetch always drives `mem_we` = 0, `mem_wstrb` = 0, `mem_wdata` = 0.
- **ISSUE**
  - `mem_req` = 1 and the `mem_*` outputs are stable.
  - On `mem_gnt` = 1: clear `mem_req`, clear the timeout counter, go to RESP.
- **RESP**
  - `mem_req` = 0. The timeout counter increments every cycle.
  - On `mem_rvalid` = 1:
    - register `mem_rdata` into the owner's `*_rdata`;
    - pulse the owner's `*_rvalid` for one cycle with `*_err` = 0;
    - go to IDLE.
  - Timeout, when the counter reaches `TIMEOUT - 1` without `mem_rvalid`:
    - pulse the owner's `*_rvalid` with `*_err` = 1 and `*_rdata` = 0;
    - go to IDLE.
  - `mem_rvalid` in the same cycle as the timeout: `mem_rvalid` wins, `err` = 0.
- `*_rdata` holds its value between responses. `d_rdata` on a store response is `mem_rdata` as returned.
- `mem_rvalid` outside RESP is ignored. Requests arriving outside IDLE wait; they are not dropped.
- `*_err` is valid only while `*_rvalid` = 1 and is 0 otherwise.
- Reset (`rst` = 0 at an edge), including mid-transaction:
  - FSM goes to IDLE; the in-flight transaction is abandoned and no `rvalid` is produced for it;
  - every output goes to 0 on the following cycle;
  - the timeout counter clears to 0;
  - `last_owner` is set to data, so the first contested grant goes to fetch.

## Timing
- All outputs are registered.
- Minimum transaction, request seen at edge E0:
  - E0 → E1: `*_gnt` = 1 and `mem_req` = 1;
  - `mem_gnt` sampled at E1 → RESP;
  - `mem_rvalid` sampled at E2 → `*_rvalid` high during E2 → E3; FSM back in IDLE.
- Next IDLE sample is at E3, so back-to-back transactions start 3 cycles apart.
- `*_gnt` and `*_rvalid` are always exactly one cycle wide.
- `mem_req` stays high for as many cycles as `mem_gnt` is delayed.

## Test plan
- Reset: `rst` = 0 for 2 cycles with both requests high → all outputs 0; the first grant after release goes to fetch (`if_gnt` = 1, `d_gnt` = 0).
- Single fetch: `if_addr` = 0x0000_0010, memory returns 0x0050_0093 with zero-wait grant and response → `if_gnt` at E1, `mem_req` for 1 cycle with `mem_addr` = 0x10 and `mem_we` = 0, `if_rvalid` at E3 with `if_rdata` = 0x0050_0093.
- Contention: both requesters held high for 4 transactions → grants alternate I, D, I, D. A store (`d_addr` 0x100, `d_wdata` 0xDEADBEEF, `d_wstrb` 0xF) appears on `mem_*` exactly as given.
- Backpressure: `mem_gnt` held low for 3 cycles → `mem_req` high for 4 cycles with stable `mem_addr`, no duplicate grant, correct `rvalid`.
- Timeout: `TIMEOUT` = 15 and `mem_rvalid` never asserted → `d_rvalid` = 1 and `d_err` = 1 with `d_rdata` = 0 exactly 15 cycles after entering RESP. Repeat with `mem_rvalid` in the same cycle as the timeout → `d_err` = 0.
- Mid-transaction reset in RESP → no `rvalid` is produced; the next transaction completes normally.
